// File: rtl/freq_div_pkg.sv
// freq_div_pkg
//   Shared definitions for the runtime clock-divider controller:
//   controller state encoding, the smallest legal divide ratio and the
//   default counter width.
package freq_div_pkg;

    localparam int DEF_CNT_W = 10;
    localparam int MIN_DIV   = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // parked, counter held at 0
        RUN  = 2'd1,  // counting, no ratio change pending
        PEND = 2'd2   // counting, next ratio waits for the period boundary
    } state_e;

endpackage

// File: rtl/freq_div_core.sv
// freq_div_core
//   Period counter with registered tick/phase generation and the register
//   holding the divide ratio currently in force.
//
// Ports:
//   clk_i       system clock
//   rst_ni      synchronous active-low reset
//   run_i       count enable; 0 clears the counter and the outputs
//   load_i      replace the ratio in force with load_div_i on this edge
//   load_div_i  ratio to load
//   cur_div_o   ratio in force
//   term_o      combinational terminal count (last cycle of the period)
//   tick_o      registered one-cycle pulse, one per period
//   phase_o     registered divided waveform, high floor(N/2) cycles
module freq_div_core
    import freq_div_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int DEF_DIV = 6
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             run_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_div_i,
    output logic [CNT_W-1:0] cur_div_o,
    output logic             term_o,
    output logic             tick_o,
    output logic             phase_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cur_div_q, cur_div_d;
    logic             tick_q, tick_d;
    logic             phase_q, phase_d;

    // cur_div_q is never below 2, so the subtraction cannot wrap.
    assign term_o = run_i && (cnt_q == (cur_div_q - CNT_W'(1)));

    always_comb begin
        cnt_d     = cnt_q;
        cur_div_d = cur_div_q;
        tick_d    = 1'b0;
        phase_d   = 1'b0;

        if (!run_i) begin
            cnt_d = '0;
        end else if (term_o) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        if (load_i) begin
            cur_div_d = load_div_i;
        end

        // Outputs lag the counter by one cycle, giving exactly one tick
        // per N clocks and a phase that starts high right after cnt=0.
        tick_d  = term_o;
        phase_d = run_i && (cnt_q < (cur_div_q >> 1));
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            cur_div_q <= CNT_W'(DEF_DIV);
            tick_q    <= 1'b0;
            phase_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            cur_div_q <= cur_div_d;
            tick_q    <= tick_d;
            phase_q   <= phase_d;
        end
    end

    assign cur_div_o = cur_div_q;
    assign tick_o    = tick_q;
    assign phase_o   = phase_q;

endmodule

// File: rtl/freq_div_ctrl.sv
// freq_div_ctrl
//   Runtime controller for the integer clock divider. Accepts new divide
//   ratios over a valid/ready handshake and applies them only at a period
//   boundary so the divided output never has a runt pulse.
//
//   Handshake: a ratio transfers on a rising clk edge where
//   cfg_valid & cfg_ready; cfg_div is sampled on that edge. cfg_ready is low
//   only while a change is pending. Ratios below 2 are accepted but dropped,
//   and cfg_err pulses the following cycle.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   enable             run request; 0 parks the divider
//   cfg_valid/ready    ratio handshake, cfg_div carries the ratio
//   cfg_err            one-cycle pulse after an illegal ratio was accepted
//   tick, phase        period pulse and divided waveform
//   busy               a ratio change is pending
//   cur_div            ratio in force
//   dbg_state          controller state (freq_div_pkg::state_e encoding)
//   period_cnt,err_cnt only with FREQ_DIV_CTRL_STATS_EN: completed periods
//                      (wrapping) and cfg_err pulses (saturating)
module freq_div_ctrl
    import freq_div_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int DEF_DIV = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_err,
    output logic             tick,
    output logic             phase,
    output logic             busy,
    output logic [CNT_W-1:0] cur_div,
    output logic [1:0]       dbg_state
`ifdef FREQ_DIV_CTRL_STATS_EN
    ,
    output logic [15:0]      period_cnt,
    output logic [7:0]       err_cnt
`endif
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             cfg_err_q, cfg_err_d;

    logic             xfer, legal, run, term;
    logic             load;
    logic [CNT_W-1:0] load_div;

    assign cfg_ready = (state_q != PEND);
    assign xfer      = cfg_valid & cfg_ready;
    assign legal     = (cfg_div >= CNT_W'(MIN_DIV));
    // Dropping enable clears the counter on the same edge the FSM goes idle.
    assign run       = (state_q != IDLE) && enable;

    always_comb begin
        state_d    = state_q;
        pend_div_d = pend_div_q;
        load       = 1'b0;
        load_div   = cfg_div;
        cfg_err_d  = xfer & ~legal;

        case (state_q)
            IDLE: begin
                if (xfer && legal) begin
                    load = 1'b1;
                end
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                    if (xfer && legal) begin
                        load = 1'b1;
                    end
                end else if (xfer && legal) begin
                    if (term) begin
                        load = 1'b1;  // on the boundary: no need to wait
                    end else begin
                        pend_div_d = cfg_div;
                        state_d    = PEND;
                    end
                end
            end
            PEND: begin
                // Commit at the boundary, or at once when parking.
                if (!enable || term) begin
                    load     = 1'b1;
                    load_div = pend_div_q;
                    state_d  = enable ? RUN : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pend_div_q <= CNT_W'(DEF_DIV);
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_div_q <= pend_div_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    freq_div_core #(
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
    ) u_core (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .run_i      (run),
        .load_i     (load),
        .load_div_i (load_div),
        .cur_div_o  (cur_div),
        .term_o     (term),
        .tick_o     (tick),
        .phase_o    (phase)
    );

    assign cfg_err   = cfg_err_q;
    assign busy      = (state_q == PEND);
    assign dbg_state = state_q;

`ifdef FREQ_DIV_CTRL_STATS_EN
    logic [15:0] period_cnt_q, period_cnt_d;
    logic [7:0]  err_cnt_q, err_cnt_d;

    always_comb begin
        period_cnt_d = period_cnt_q;
        err_cnt_d    = err_cnt_q;
        if (tick) begin
            period_cnt_d = period_cnt_q + 16'd1;
        end
        if (cfg_err_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            period_cnt_q <= '0;
            err_cnt_q    <= '0;
        end else begin
            period_cnt_q <= period_cnt_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign period_cnt = period_cnt_q;
    assign err_cnt    = err_cnt_q;
`endif

endmodule
